// File: rtl/invaders_pkg.sv
// ---------------------------------------------------------------------------
// invaders_pkg
// Shared playfield constants and types for the invader formation logic.
//   COORD_W      : width of an x-coordinate in pixels (11 bits, 0..2047)
//   X_*_DEF/STEP : default playfield limits, start position and step size
//   dir_e        : horizontal direction of the formation
//   coord_ext_t  : coordinate with one guard bit for overflow-free compares
// ---------------------------------------------------------------------------
package invaders_pkg;

   localparam int COORD_W    = 11;
   localparam int X_INIT_DEF = 100;
   localparam int X_MIN_DEF  = 10;
   localparam int X_MAX_DEF  = 500;
   localparam int STEP_DEF   = 10;

   typedef enum logic {
      DIR_RIGHT = 1'b0,
      DIR_LEFT  = 1'b1
   } dir_e;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [COORD_W:0]   coord_ext_t;

   // Zero-extend a coordinate by one bit so sums up to 2047 + STEP fit.
   function automatic coord_ext_t extend(input coord_t c);
      return {1'b0, c};
   endfunction

endpackage

// File: rtl/rise_detect.sv
// ---------------------------------------------------------------------------
// rise_detect
// Single-cycle pulse on the 0->1 transition of a level input.
//   clk   : clock
//   reset : synchronous active-high reset (clears the history bit)
//   d     : level input
//   pulse : d & ~(d on previous edge); combinational from d
// The history bit resets to 0, so a level already high on the first
// post-reset edge is treated as a fresh rise.
// ---------------------------------------------------------------------------
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic pulse
);

   logic d_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         d_q <= 1'b0;
      end else begin
         d_q <= d;
      end
   end

   assign pulse = d & ~d_q;

endmodule

// File: rtl/moven_logic.sv
// ---------------------------------------------------------------------------
// moven_logic
// Horizontal movement controller for the invader formation. Holds the
// x-coordinate of the reference enemy and moves it STEP pixels per rising
// edge of mueva, bouncing between X_MIN and X_MAX.
//   clk    : system clock
//   reset  : synchronous active-high reset (pos=X_INIT, direction right)
//   mueva  : movement request level; each 0->1 transition is one step
//   posxE1 : current x-coordinate of enemy 1, straight from a register
// ---------------------------------------------------------------------------
module moven_logic
   import invaders_pkg::*;
#(
   parameter int X_INIT = X_INIT_DEF,
   parameter int X_MIN  = X_MIN_DEF,
   parameter int X_MAX  = X_MAX_DEF,
   parameter int STEP   = STEP_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               mueva,
   output logic [COORD_W-1:0] posxE1
);

   // Reject nonsensical playfield configurations at elaboration.
   if (STEP <= 0 || X_MIN > X_INIT || X_INIT > X_MAX || X_MAX > 2047) begin : g_param_check
      $error("moven_logic: illegal parameters (need STEP>0, X_MIN<=X_INIT<=X_MAX<=2047)");
   end

   localparam coord_t     X_INIT_C = coord_t'(X_INIT);
   localparam coord_t     X_MIN_C  = coord_t'(X_MIN);
   localparam coord_t     X_MAX_C  = coord_t'(X_MAX);
   localparam coord_t     STEP_C   = coord_t'(STEP);
   localparam coord_ext_t STEP_X   = coord_ext_t'(STEP);
   localparam coord_ext_t X_MAX_X  = coord_ext_t'(X_MAX);
   localparam coord_ext_t LO_TURN  = coord_ext_t'(X_MIN + STEP);

   coord_t     pos_q, pos_d;
   dir_e       dir_q, dir_d;
   logic       tick;
   coord_ext_t pos_plus;

   rise_detect u_rise (
      .clk   (clk),
      .reset (reset),
      .d     (mueva),
      .pulse (tick)
   );

   assign pos_plus = extend(pos_q) + STEP_X;

   // Next position. The step that reaches or would pass a bound lands on the
   // bound and flips direction in the same edge, so there is no dwell step.
   always_comb begin
      pos_d = pos_q;
      dir_d = dir_q;
      if (tick) begin
         if (dir_q == DIR_RIGHT) begin
            if (pos_plus >= X_MAX_X) begin
               pos_d = X_MAX_C;
               dir_d = DIR_LEFT;
            end else begin
               pos_d = pos_plus[COORD_W-1:0];
            end
         end else begin
            if (extend(pos_q) <= LO_TURN) begin
               pos_d = X_MIN_C;
               dir_d = DIR_RIGHT;
            end else begin
               pos_d = pos_q - STEP_C;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pos_q <= X_INIT_C;
         dir_q <= DIR_RIGHT;
      end else begin
         pos_q <= pos_d;
         dir_q <= dir_d;
      end
   end

   assign posxE1 = pos_q;

endmodule

// File: tb/tb_moven_logic.sv
// ---------------------------------------------------------------------------
// tb_moven_logic
// Directed bench for moven_logic: default instance plus an X_MAX=505 copy.
// ---------------------------------------------------------------------------
module tb_moven_logic;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mueva = 1'b0;
   logic        mueva2 = 1'b0;
   logic [10:0] posxE1;
   logic [10:0] posxE1_b;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   moven_logic dut (
      .clk    (clk),
      .reset  (reset),
      .mueva  (mueva),
      .posxE1 (posxE1)
   );

   moven_logic #(.X_MAX(505)) dut_b (
      .clk    (clk),
      .reset  (reset),
      .mueva  (mueva2),
      .posxE1 (posxE1_b)
   );

   task automatic do_reset();
      @(negedge clk);
      reset  = 1'b1;
      mueva  = 1'b0;
      mueva2 = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // One clean pulse on the default instance: 1 cycle high, 3 low.
   task automatic pulse_a();
      mueva = 1'b1;
      @(negedge clk);
      mueva = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic pulse_b();
      mueva2 = 1'b1;
      @(negedge clk);
      mueva2 = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      int bad;
      bad = 0;
      @(negedge clk);
      reset = 1'b1;
      mueva = 1'b0;
      mueva2 = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (posxE1 !== 11'd100) bad++;
      end
      reset = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (posxE1 !== 11'd100) bad++;
      end
      total_cnt++;
      if (bad == 0 && posxE1 === 11'd100) pass_cnt++;
      else $display("FAIL reset_idle: posxE1=%0d bad_cycles=%0d, expected 100 throughout", posxE1, bad);
      $display("test_reset: posxE1=%0d after 20 idle cycles", posxE1);
      total_cnt++;
      if (posxE1_b === 11'd100) pass_cnt++;
      else $display("FAIL reset_b: posxE1_b=%0d expected 100", posxE1_b);
   endtask

   task automatic test_pulses();
      logic [10:0] exp_v;
      do_reset();
      exp_v = 11'd100;
      for (int i = 0; i < 3; i++) begin
         mueva = 1'b1;
         total_cnt++;
         if (posxE1 === exp_v) pass_cnt++;
         else $display("FAIL pulse_pre%0d: posxE1=%0d expected %0d", i, posxE1, exp_v);
         @(negedge clk);
         exp_v = exp_v + 11'd10;
         total_cnt++;
         if (posxE1 === exp_v) pass_cnt++;
         else $display("FAIL pulse_step%0d: posxE1=%0d expected %0d", i, posxE1, exp_v);
         $display("test_pulses: pulse %0d posxE1=%0d", i, posxE1);
         mueva = 1'b0;
         repeat (3) @(negedge clk);
      end
   endtask

   task automatic test_held_high();
      int bad;
      bad = 0;
      do_reset();
      mueva = 1'b1;
      repeat (50) begin
         @(negedge clk);
         if (posxE1 !== 11'd110) bad++;
      end
      total_cnt++;
      if (bad == 0) pass_cnt++;
      else $display("FAIL held_high: posxE1=%0d bad_cycles=%0d expected 110 for 50 cycles", posxE1, bad);
      mueva = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (posxE1 === 11'd110) pass_cnt++;
      else $display("FAIL held_drop: posxE1=%0d expected 110", posxE1);
      pulse_a();
      total_cnt++;
      if (posxE1 === 11'd120) pass_cnt++;
      else $display("FAIL held_rerise: posxE1=%0d expected 120", posxE1);
      $display("test_held_high: after re-rise posxE1=%0d", posxE1);
   endtask

   task automatic test_bounce();
      do_reset();
      repeat (40) pulse_a();
      total_cnt++;
      if (posxE1 === 11'd500) pass_cnt++;
      else $display("FAIL bounce_right_edge: posxE1=%0d expected 500", posxE1);
      pulse_a();
      total_cnt++;
      if (posxE1 === 11'd490) pass_cnt++;
      else $display("FAIL bounce_turn_left: posxE1=%0d expected 490", posxE1);
      repeat (48) pulse_a();
      total_cnt++;
      if (posxE1 === 11'd10) pass_cnt++;
      else $display("FAIL bounce_left_edge: posxE1=%0d expected 10", posxE1);
      pulse_a();
      total_cnt++;
      if (posxE1 === 11'd20) pass_cnt++;
      else $display("FAIL bounce_turn_right: posxE1=%0d expected 20", posxE1);
      $display("test_bounce: final posxE1=%0d", posxE1);
   endtask

   task automatic test_xmax_override();
      do_reset();
      repeat (40) pulse_b();
      total_cnt++;
      if (posxE1_b === 11'd500) pass_cnt++;
      else $display("FAIL clamp_pre: posxE1_b=%0d expected 500", posxE1_b);
      pulse_b();
      total_cnt++;
      if (posxE1_b === 11'd505) pass_cnt++;
      else $display("FAIL clamp_max: posxE1_b=%0d expected 505", posxE1_b);
      pulse_b();
      total_cnt++;
      if (posxE1_b === 11'd495) pass_cnt++;
      else $display("FAIL clamp_back: posxE1_b=%0d expected 495", posxE1_b);
      total_cnt++;
      if (posxE1 === 11'd100) pass_cnt++;
      else $display("FAIL clamp_isolation: posxE1=%0d expected 100", posxE1);
      $display("test_xmax_override: posxE1_b=%0d", posxE1_b);
   endtask

   task automatic test_reset_mid_motion();
      do_reset();
      repeat (60) pulse_a();
      total_cnt++;
      if (posxE1 === 11'd300) pass_cnt++;
      else $display("FAIL midreset_pre: posxE1=%0d expected 300", posxE1);
      mueva = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (posxE1 === 11'd100) pass_cnt++;
      else $display("FAIL midreset_override: posxE1=%0d expected 100", posxE1);
      mueva = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (posxE1 === 11'd100) pass_cnt++;
      else $display("FAIL midreset_hold: posxE1=%0d expected 100", posxE1);
      pulse_a();
      total_cnt++;
      if (posxE1 === 11'd110) pass_cnt++;
      else $display("FAIL midreset_dir: posxE1=%0d expected 110", posxE1);
      $display("test_reset_mid_motion: posxE1=%0d", posxE1);
   endtask

   task automatic test_first_edge_rise();
      // mueva already high when reset drops: the first edge is a step.
      @(negedge clk);
      reset = 1'b1;
      mueva = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (posxE1 === 11'd110) pass_cnt++;
      else $display("FAIL first_edge: posxE1=%0d expected 110", posxE1);
      mueva = 1'b0;
      @(negedge clk);
      $display("test_first_edge_rise: posxE1=%0d", posxE1);
   endtask

   initial begin
      test_reset();
      test_pulses();
      test_held_high();
      test_bounce();
      test_xmax_override();
      test_reset_mid_motion();
      test_first_edge_rise();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
